dmem_arbiter: RTL

//  Two-requester arbiter/sequencer in front of the data memory. Port 0 is the CPU load/store unit;

---
 rtl/dmem_arbiter_if.sv | 23 ++
 rtl/dmem_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter.
// One instance per requester port.
interface dmem_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic        ack;
    logic        done;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, wdata, funct3,
        input  ack, done, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, funct3,
        output ack, done, rdata, err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of data memory.
// Port 0 = load/store unit, port 1 = debug/DMA loader.
module dmem_arbiter #(
    parameter int ADDR_BITS  = 12,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    dmem_arbiter_if.slave p0,
    dmem_arbiter_if.slave p1,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic [2:0]  mem_funct3,
    output logic        mem_read_en,
    output logic        mem_write_en,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_last_grant;
    logic        r_port;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic        r_err;
    logic [31:0] r_rdata;

    logic        w_any;
    logic        w_open;
    logic        w_accept;
    logic        w_sel;
    logic        w_we;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [2:0]  w_funct3;
    logic        w_illegal;
    logic        w_misal;
    logic        w_oor;
    logic        w_err;

    assign w_any    = p0.req | p1.req;
    assign w_open   = (r_state == ST_IDLE) || (r_state == ST_RESP);
    assign w_accept = w_open & w_any;

    // Winner selection: on a tie the port that did not win last time goes
    always_comb begin
        w_sel = p1.req;
        if (p0.req && p1.req) begin
            w_sel = FIXED_PRIO ? 1'b0 : ~r_last_grant;
        end
    end

    // Mux the winning request and classify it
    always_comb begin
        w_we     = w_sel ? p1.we     : p0.we;
        w_addr   = w_sel ? p1.addr   : p0.addr;
        w_wdata  = w_sel ? p1.wdata  : p0.wdata;
        w_funct3 = w_sel ? p1.funct3 : p0.funct3;
        w_illegal = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) ||
                    (w_funct3 == 3'b111) || (w_we && w_funct3[2]);
        w_misal = ((w_funct3[1:0] == 2'b01) && w_addr[0]) ||
                  ((w_funct3 == 3'b010) && (w_addr[1:0] != 2'b00));
        w_oor   = |(w_addr >> ADDR_BITS);
        w_err   = w_illegal | w_misal | w_oor;
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:   w_next = w_any ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: w_next = ST_RESP;
            ST_RESP:   w_next = w_any ? ST_ACCESS : ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Latch the accepted request and capture load data at the access edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= 1'b1;
            r_port       <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_funct3     <= '0;
            r_err        <= 1'b0;
            r_rdata      <= '0;
        end else begin
            if (w_accept) begin
                r_last_grant <= w_sel;
                r_port       <= w_sel;
                r_we         <= w_we;
                r_addr       <= w_addr;
                r_wdata      <= w_wdata;
                r_funct3     <= w_funct3;
                r_err        <= w_err;
            end
            if (r_state == ST_ACCESS) begin
                r_rdata <= (!r_we && !r_err) ? mem_read_data : '0;
            end
        end
    end

    // Handshake, memory drive and response outputs
    always_comb begin
        p0.ack         = w_accept & ~w_sel;
        p1.ack         = w_accept & w_sel;
        p0.done        = 1'b0;
        p0.rdata       = '0;
        p0.err         = 1'b0;
        p1.done        = 1'b0;
        p1.rdata       = '0;
        p1.err         = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        mem_funct3     = '0;
        mem_read_en    = 1'b0;
        mem_write_en   = 1'b0;
        if (r_state == ST_ACCESS) begin
            mem_address    = r_addr;
            mem_write_data = r_wdata;
            mem_funct3     = r_funct3;
            mem_write_en   = r_we & ~r_err;
            mem_read_en    = ~r_we & ~r_err;
        end
        if (r_state == ST_RESP) begin
            if (r_port) begin
                p1.done  = 1'b1;
                p1.rdata = r_rdata;
                p1.err   = r_err;
            end else begin
                p0.done  = 1'b1;
                p0.rdata = r_rdata;
                p0.err   = r_err;
            end
        end
    end

endmodule
